// File: rtl/register_file.sv
// General-purpose register bank: DEPTH x WIDTH entries with two combinational
// read ports and one synchronous write port. Entry 0 is hardwired to zero.
// With BYPASS set, a legal write is forwarded to the read ports in the same
// cycle. Writes to entry 0 or beyond DEPTH-1 are dropped and raise no wr_ack.
module register_file #(
   parameter int               WIDTH     = 32,
   parameter int               DEPTH     = 32,
   parameter int               ADDR_W    = 5,
   parameter int               BYPASS    = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [WIDTH-1:0]  rdata1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [WIDTH-1:0]  rdata2,
   output logic              wr_ack
);

   genvar gi;

   // Entry 0 is never stored; the array starts at index 1.
   // Every entry is reset, so the bank is built from flops rather than RAM.
   logic [WIDTH-1:0] mem_reg [1:DEPTH-1];
   logic             wr_ack_reg;
   logic             waddr_legal;
   logic             bypass_en;

   // A write target must be non-zero and inside the populated range.
   assign waddr_legal = (waddr != '0) && (32'(waddr) < DEPTH);

   // Forwarding is only meaningful when the write will actually land, and is
   // held off during reset so reads show the stored contents.
   assign bypass_en = (BYPASS != 0) && RST_N && we && waddr_legal;

   // Storage update: reset loads RESET_VAL everywhere, otherwise one legal write.
   always_ff @(posedge CLK) begin
      for (int i = 1; i < DEPTH; i++) begin
         if (!RST_N) begin
            mem_reg[i] <= RESET_VAL;
         end else if (we && waddr_legal && (waddr == ADDR_W'(i))) begin
            mem_reg[i] <= wdata;
         end
      end
   end

   // Write acknowledge: one-cycle pulse following each accepted write.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         wr_ack_reg <= 1'b0;
      end else begin
         wr_ack_reg <= we && waddr_legal;
      end
   end

   assign wr_ack = wr_ack_reg;

   // Two identical read ports; index 0 serves raddr1, index 1 serves raddr2.
   for (gi = 0; gi < 2; gi++) begin : g_rport
      logic [ADDR_W-1:0] raddr_sel;
      logic [WIDTH-1:0]  rdata_next;

      assign raddr_sel = (gi == 0) ? raddr1 : raddr2;

      // Read mux: zero by default (covers entry 0 and out-of-range), stored
      // entry on a match, forwarded write data when bypass applies.
      always_comb begin
         rdata_next = '0;
         for (int i = 1; i < DEPTH; i++) begin
            if (raddr_sel == ADDR_W'(i)) begin
               rdata_next = mem_reg[i];
            end
         end
         if (bypass_en && (raddr_sel == waddr)) begin
            rdata_next = wdata;
         end
      end
   end

   assign rdata1 = g_rport[0].rdata_next;
   assign rdata2 = g_rport[1].rdata_next;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file. Three instances share one stimulus stream:
// default (BYPASS=1, DEPTH=32, RESET_VAL=0), no-bypass with a non-zero reset
// value, and a DEPTH=16 bank for the out-of-range cases.
module tb_register_file;

   localparam logic [31:0] RV = 32'hC0DE_0001;

   logic        clk;
   logic        rst_n;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddr1;
   logic [4:0]  raddr2;

   logic [31:0] m_rd1, m_rd2, n_rd1, n_rd2, d_rd1, d_rd2;
   logic        m_ack, n_ack, d_ack;

   int checks   = 0;
   int failures = 0;

   register_file u_main (
      .CLK(clk), .RST_N(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .rdata1(m_rd1), .raddr2(raddr2), .rdata2(m_rd2),
      .wr_ack(m_ack)
   );

   register_file #(.BYPASS(0), .RESET_VAL(RV)) u_nobyp (
      .CLK(clk), .RST_N(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .rdata1(n_rd1), .raddr2(raddr2), .rdata2(n_rd2),
      .wr_ack(n_ack)
   );

   register_file #(.DEPTH(16)) u_d16 (
      .CLK(clk), .RST_N(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .rdata1(d_rd1), .raddr2(raddr2), .rdata2(d_rd2),
      .wr_ack(d_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic        chk_rd;   // pre-edge reads are meaningful
      logic [31:0] m1;       // main instance, pre-edge reads and post-edge ack
      logic [31:0] m2;
      logic        mack;
      logic [31:0] n1;       // no-bypass instance
      logic        nack;
      logic [31:0] d1;       // DEPTH=16 instance
      logic [31:0] d2;
      logic        dack;
   } vec_t;

   localparam int NVEC = 20;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step=%0d actual=%h expected=%h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic w, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] a1,
                        input logic [4:0] a2);
      rst_n  = r;
      we     = w;
      waddr  = wa;
      wdata  = wd;
      raddr1 = a1;
      raddr2 = a2;
   endtask

   initial begin
      //          rst we wa  wd             ra1 ra2 chk  m1            m2            mack n1            nack d1            d2            dack
      vecs[0]  = '{1'b0,1'b1,5'd5, 32'hDEAD_BEEF,5'd5, 5'd0, 1'b0, 32'h0,        32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'h0,        1'b0};
      vecs[1]  = '{1'b1,1'b0,5'd0, 32'h0,        5'd5, 5'd0, 1'b1, 32'h0,        32'h0,        1'b0,RV,           1'b0,32'h0,        32'h0,        1'b0};
      vecs[2]  = '{1'b1,1'b1,5'd3, 32'hFFFF_1111,5'd3, 5'd31,1'b1, 32'hFFFF_1111,32'h0,        1'b1,RV,           1'b1,32'hFFFF_1111,32'h0,        1'b1};
      vecs[3]  = '{1'b1,1'b1,5'd31,32'h0000_0001,5'd3, 5'd31,1'b1, 32'hFFFF_1111,32'h0000_0001,1'b1,32'hFFFF_1111,1'b1,32'hFFFF_1111,32'h0,        1'b0};
      vecs[4]  = '{1'b1,1'b0,5'd0, 32'h0,        5'd3, 5'd31,1'b1, 32'hFFFF_1111,32'h0000_0001,1'b0,32'hFFFF_1111,1'b0,32'hFFFF_1111,32'h0,        1'b0};
      vecs[5]  = '{1'b1,1'b1,5'd0, 32'hF001_0001,5'd0, 5'd0, 1'b1, 32'h0,        32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'h0,        1'b0};
      vecs[6]  = '{1'b1,1'b0,5'd0, 32'h0,        5'd0, 5'd3, 1'b1, 32'h0,        32'hFFFF_1111,1'b0,32'h0,        1'b0,32'h0,        32'hFFFF_1111,1'b0};
      vecs[7]  = '{1'b1,1'b1,5'd7, 32'h0001_0001,5'd7, 5'd7, 1'b1, 32'h0001_0001,32'h0001_0001,1'b1,RV,           1'b1,32'h0001_0001,32'h0001_0001,1'b1};
      vecs[8]  = '{1'b1,1'b1,5'd7, 32'h1234_5678,5'd7, 5'd7, 1'b1, 32'h1234_5678,32'h1234_5678,1'b1,32'h0001_0001,1'b1,32'h1234_5678,32'h1234_5678,1'b1};
      vecs[9]  = '{1'b1,1'b0,5'd0, 32'h0,        5'd7, 5'd7, 1'b1, 32'h1234_5678,32'h1234_5678,1'b0,32'h1234_5678,1'b0,32'h1234_5678,32'h1234_5678,1'b0};
      vecs[10] = '{1'b1,1'b1,5'd20,32'hAAAA_AAAA,5'd20,5'd3, 1'b1, 32'hAAAA_AAAA,32'hFFFF_1111,1'b1,RV,           1'b1,32'h0,        32'hFFFF_1111,1'b0};
      vecs[11] = '{1'b1,1'b0,5'd0, 32'h0,        5'd20,5'd4, 1'b1, 32'hAAAA_AAAA,32'h0,        1'b0,32'hAAAA_AAAA,1'b0,32'h0,        32'h0,        1'b0};
      vecs[12] = '{1'b1,1'b1,5'd9, 32'h5555_5555,5'd9, 5'd9, 1'b1, 32'h5555_5555,32'h5555_5555,1'b1,RV,           1'b1,32'h5555_5555,32'h5555_5555,1'b1};
      vecs[13] = '{1'b0,1'b1,5'd9, 32'h6666_6666,5'd9, 5'd9, 1'b1, 32'h5555_5555,32'h5555_5555,1'b0,32'h5555_5555,1'b0,32'h5555_5555,32'h5555_5555,1'b0};
      vecs[14] = '{1'b1,1'b0,5'd0, 32'h0,        5'd9, 5'd3, 1'b1, 32'h0,        32'h0,        1'b0,RV,           1'b0,32'h0,        32'h0,        1'b0};
      vecs[15] = '{1'b1,1'b1,5'd9, 32'h7777_7777,5'd9, 5'd20,1'b1, 32'h7777_7777,32'h0,        1'b1,RV,           1'b1,32'h7777_7777,32'h0,        1'b1};
      vecs[16] = '{1'b1,1'b0,5'd0, 32'h0,        5'd9, 5'd20,1'b1, 32'h7777_7777,32'h0,        1'b0,32'h7777_7777,1'b0,32'h7777_7777,32'h0,        1'b0};
      vecs[17] = '{1'b1,1'b1,5'd12,32'h1111_2222,5'd12,5'd12,1'b1, 32'h1111_2222,32'h1111_2222,1'b1,RV,           1'b1,32'h1111_2222,32'h1111_2222,1'b1};
      vecs[18] = '{1'b1,1'b1,5'd12,32'h3333_4444,5'd12,5'd1, 1'b1, 32'h3333_4444,32'h0,        1'b1,32'h1111_2222,1'b1,32'h3333_4444,32'h0,        1'b1};
      vecs[19] = '{1'b1,1'b0,5'd0, 32'h0,        5'd12,5'd12,1'b1, 32'h3333_4444,32'h3333_4444,1'b0,32'h3333_4444,1'b0,32'h3333_4444,32'h3333_4444,1'b0};

      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

      // Table: apply on the falling edge, check reads before the rising edge,
      // check wr_ack just after it.
      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         drive(vecs[i].rst_n, vecs[i].we, vecs[i].wa, vecs[i].wd,
               vecs[i].ra1, vecs[i].ra2);
         #1;
         $display("vec %0d rst_n=%0b we=%0b waddr=%0d wdata=%h raddr1=%0d raddr2=%0d rdata1=%h rdata2=%h",
                  i, rst_n, we, waddr, wdata, raddr1, raddr2, m_rd1, m_rd2);
         if (vecs[i].chk_rd) begin
            chk("main_rdata1", i, m_rd1, vecs[i].m1);
            chk("main_rdata2", i, m_rd2, vecs[i].m2);
            chk("nobyp_rdata1", i, n_rd1, vecs[i].n1);
            chk("d16_rdata1", i, d_rd1, vecs[i].d1);
            chk("d16_rdata2", i, d_rd2, vecs[i].d2);
         end
         @(posedge clk);
         #1;
         chk("main_wr_ack", i, {31'b0, m_ack}, {31'b0, vecs[i].mack});
         chk("nobyp_wr_ack", i, {31'b0, n_ack}, {31'b0, vecs[i].nack});
         chk("d16_wr_ack", i, {31'b0, d_ack}, {31'b0, vecs[i].dack});
      end

      // Reset held for two edges with a write pending: nothing lands.
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         drive(1'b0, 1'b1, 5'd12, 32'hFFFF_FFFF, 5'd12, 5'd0);
         #1;
         $display("rst %0d rst_n=%0b we=%0b waddr=%0d rdata1=%h nobyp_rdata1=%h",
                  k, rst_n, we, waddr, m_rd1, n_rd1);
         chk("rst_main_pre", 100 + k, m_rd1, (k == 0) ? 32'h3333_4444 : 32'h0);
         chk("rst_nobyp_pre", 100 + k, n_rd1, (k == 0) ? 32'h3333_4444 : RV);
         chk("rst_nobyp_rd2", 100 + k, n_rd2, 32'h0);
         @(posedge clk);
         #1;
         chk("rst_main_post", 100 + k, m_rd1, 32'h0);
         chk("rst_nobyp_post", 100 + k, n_rd1, RV);
         chk("rst_main_ack", 100 + k, {31'b0, m_ack}, 32'h0);
      end

      // Single write after reset, then idle: wr_ack is a one-cycle pulse.
      @(negedge clk);
      drive(1'b1, 1'b1, 5'd2, 32'h0BAD_F00D, 5'd2, 5'd12);
      @(posedge clk);
      #1;
      $display("wr  waddr=2 wdata=0badf00d wr_ack=%0b nobyp_rdata1=%h", m_ack, n_rd1);
      chk("pulse_ack_hi", 200, {31'b0, m_ack}, 32'h1);
      chk("pulse_nobyp_rd", 200, n_rd1, 32'h0BAD_F00D);
      chk("pulse_nobyp_rd2", 200, n_rd2, RV);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         drive(1'b1, 1'b0, 5'd2, 32'h0, 5'd2, 5'd0);
         @(posedge clk);
         #1;
         $display("idle %0d wr_ack=%0b rdata1=%h", k, m_ack, m_rd1);
         chk("pulse_ack_lo", 201 + k, {31'b0, m_ack}, 32'h0);
         chk("pulse_main_rd", 201 + k, m_rd1, 32'h0BAD_F00D);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
